// File: rtl/traffic_phase_sequencer.sv
// Demand-actuated round-robin traffic phase sequencer with min/max green,
// yellow plus all-red clearance, and a red-flash override.
module traffic_phase_sequencer #(
  parameter int NUM_PHASES  = 4,
  parameter int TW          = 8,
  parameter int MIN_GREEN   = 4,
  parameter int MAX_GREEN   = 10,
  parameter int YELLOW_TIME = 2,
  parameter int ALLRED_TIME = 1,
  parameter int FLASH_TIME  = 3,
  localparam int PW = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_PHASES-1:0] req,
  input  logic                  fixed_mode,
  input  logic                  flash,
  output logic [NUM_PHASES-1:0] grn,
  output logic [NUM_PHASES-1:0] yel,
  output logic [NUM_PHASES-1:0] red,
  output logic [PW-1:0]         cur_phase,
  output logic                  in_flash
);

  typedef enum logic [1:0] {
    S_ALL_RED,
    S_GREEN,
    S_YELLOW,
    S_FLASH
  } state_t;

  state_t                state, state_nxt;
  logic [TW-1:0]         timer, timer_nxt;
  logic [TW-1:0]         green_cnt, green_cnt_nxt;
  logic [PW-1:0]         cur_phase_nxt, next_phase, cand;
  logic [NUM_PHASES-1:0] demand, demand_nxt, eff_dem, phase_bit;
  logic                  flash_on, flash_on_nxt;
  logic                  found, conflict, end_green;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_ALL_RED;
      timer     <= TW'(ALLRED_TIME - 1);
      green_cnt <= '0;
      cur_phase <= PW'(NUM_PHASES - 1);
      demand    <= '0;
      flash_on  <= 1'b1;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      green_cnt <= green_cnt_nxt;
      cur_phase <= cur_phase_nxt;
      demand    <= demand_nxt;
      flash_on  <= flash_on_nxt;
    end
  end

  always_comb begin
    phase_bit            = '0;
    phase_bit[cur_phase] = 1'b1;
  end

  // Round-robin search starting just after the last served phase; the
  // current phase itself is the last candidate considered.
  always_comb begin
    eff_dem    = fixed_mode ? '1 : demand;
    found      = 1'b0;
    next_phase = cur_phase;
    cand       = cur_phase;
    for (int k = 1; k <= NUM_PHASES; k++) begin
      cand = PW'((int'(cur_phase) + k) % NUM_PHASES);
      if (!found && eff_dem[cand]) begin
        found      = 1'b1;
        next_phase = cand;
      end
    end
  end

  always_comb begin
    demand_nxt = demand | req;
    if (state == S_GREEN) demand_nxt[cur_phase] = 1'b0;
    conflict  = |(eff_dem & ~phase_bit);
    end_green = 1'b0;
    if (flash)
      end_green = 1'b1;
    else if (fixed_mode)
      end_green = (green_cnt == TW'(MAX_GREEN));
    else
      end_green = (green_cnt >= TW'(MIN_GREEN)) && conflict &&
                  (!req[cur_phase] || (green_cnt >= TW'(MAX_GREEN)));
  end

  always_comb begin
    state_nxt     = state;
    timer_nxt     = timer;
    green_cnt_nxt = green_cnt;
    cur_phase_nxt = cur_phase;
    flash_on_nxt  = flash_on;
    case (state)
      S_ALL_RED: begin
        if (timer != '0) begin
          timer_nxt = timer - 1'b1;
        end else if (flash) begin
          state_nxt    = S_FLASH;
          timer_nxt    = TW'(FLASH_TIME - 1);
          flash_on_nxt = 1'b1;
        end else if (found) begin
          state_nxt     = S_GREEN;
          cur_phase_nxt = next_phase;
          green_cnt_nxt = TW'(1);
        end
      end
      S_GREEN: begin
        if (green_cnt != '1) green_cnt_nxt = green_cnt + 1'b1;
        if (end_green) begin
          state_nxt = S_YELLOW;
          timer_nxt = TW'(YELLOW_TIME - 1);
        end
      end
      S_YELLOW: begin
        if (timer != '0) begin
          timer_nxt = timer - 1'b1;
        end else begin
          state_nxt = S_ALL_RED;
          timer_nxt = TW'(ALLRED_TIME - 1);
        end
      end
      S_FLASH: begin
        // Leaving flash always re-enters a full all-red clearance.
        if (!flash) begin
          state_nxt = S_ALL_RED;
          timer_nxt = TW'(ALLRED_TIME - 1);
        end else if (timer != '0) begin
          timer_nxt = timer - 1'b1;
        end else begin
          flash_on_nxt = ~flash_on;
          timer_nxt    = TW'(FLASH_TIME - 1);
        end
      end
      default: state_nxt = S_ALL_RED;
    endcase
  end

  always_comb begin
    grn      = '0;
    yel      = '0;
    red      = '1;
    in_flash = 1'b0;
    case (state)
      S_GREEN: begin
        grn = phase_bit;
        red = ~phase_bit;
      end
      S_YELLOW: begin
        yel = phase_bit;
        red = ~phase_bit;
      end
      S_FLASH: begin
        in_flash = 1'b1;
        red      = flash_on ? '1 : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic, compared each
// cycle against an interval/age based model of the sequencer.
module tb_traffic_phase_sequencer;

  localparam int NP    = 4;
  localparam int MIN_G = 4;
  localparam int MAX_G = 10;
  localparam int YEL_T = 2;
  localparam int AR_T  = 1;
  localparam int FL_T  = 3;
  localparam int SAT   = 255;

  localparam int M_RED   = 0;
  localparam int M_GREEN = 1;
  localparam int M_YEL   = 2;
  localparam int M_FLASH = 3;

  logic          clk;
  logic          reset;
  logic          fixed_mode;
  logic          flash;
  logic [NP-1:0] req;
  logic [NP-1:0] grn, yel, red;
  logic [1:0]    cur_phase;
  logic          in_flash;

  int    checks;
  int    errors;
  string cur_test;

  int m_mode;
  int m_age;
  int m_phase;
  bit m_dem [NP];

  traffic_phase_sequencer #(
    .NUM_PHASES (NP),
    .TW         (8),
    .MIN_GREEN  (MIN_G),
    .MAX_GREEN  (MAX_G),
    .YELLOW_TIME(YEL_T),
    .ALLRED_TIME(AR_T),
    .FLASH_TIME (FL_T)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .fixed_mode(fixed_mode),
    .flash     (flash),
    .grn       (grn),
    .yel       (yel),
    .red       (red),
    .cur_phase (cur_phase),
    .in_flash  (in_flash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s/%s observed=%0h expected=%0h", cur_test, tag, obs, exp);
    end
  endtask

  // Model: each state is an interval whose age counts up from 0; the green
  // count is age+1 and the flash half is derived from age / FL_T.
  task automatic model_step(input logic [NP-1:0] r, input logic fm, input logic fl, input logic rs);
    bit eff [NP];
    bit nd  [NP];
    bit conflict;
    bit done;
    int gcount;
    int base;
    int cand;
    if (rs) begin
      m_mode  = M_RED;
      m_age   = 0;
      m_phase = NP - 1;
      for (int i = 0; i < NP; i++) m_dem[i] = 1'b0;
      return;
    end
    for (int i = 0; i < NP; i++) begin
      eff[i] = fm ? 1'b1 : m_dem[i];
      nd[i]  = (m_mode == M_GREEN && m_phase == i) ? 1'b0 : (m_dem[i] | r[i]);
    end
    case (m_mode)
      M_RED: begin
        if (m_age + 1 < AR_T) begin
          m_age++;
        end else if (fl) begin
          m_mode = M_FLASH;
          m_age  = 0;
        end else begin
          done = 1'b0;
          base = m_phase;
          for (int k = 1; k <= NP; k++) begin
            cand = (base + k) % NP;
            if (!done && eff[cand]) begin
              done    = 1'b1;
              m_mode  = M_GREEN;
              m_phase = cand;
              m_age   = 0;
            end
          end
          if (!done) m_age++;
        end
      end
      M_GREEN: begin
        gcount   = (m_age + 1 > SAT) ? SAT : m_age + 1;
        conflict = 1'b0;
        for (int i = 0; i < NP; i++)
          if (i != m_phase && eff[i]) conflict = 1'b1;
        if (fl || (fm && gcount == MAX_G) ||
            (!fm && gcount >= MIN_G && conflict && (!r[m_phase] || gcount >= MAX_G))) begin
          m_mode = M_YEL;
          m_age  = 0;
        end else begin
          m_age++;
        end
      end
      M_YEL: begin
        if (m_age + 1 >= YEL_T) begin
          m_mode = M_RED;
          m_age  = 0;
        end else begin
          m_age++;
        end
      end
      default: begin
        if (!fl) begin
          m_mode = M_RED;
          m_age  = 0;
        end else begin
          m_age++;
        end
      end
    endcase
    for (int i = 0; i < NP; i++) m_dem[i] = nd[i];
  endtask

  task automatic apply_stimulus(input logic [NP-1:0] r, input logic fm, input logic fl, input logic rs);
    logic [NP-1:0] e_grn, e_yel, e_red;
    logic          e_fl;
    req        = r;
    fixed_mode = fm;
    flash      = fl;
    reset      = rs;
    model_step(r, fm, fl, rs);
    @(posedge clk);
    #1;
    e_grn = '0;
    e_yel = '0;
    e_red = '1;
    e_fl  = 1'b0;
    case (m_mode)
      M_GREEN: begin
        e_grn[m_phase] = 1'b1;
        e_red[m_phase] = 1'b0;
      end
      M_YEL: begin
        e_yel[m_phase] = 1'b1;
        e_red[m_phase] = 1'b0;
      end
      M_FLASH: begin
        e_fl  = 1'b1;
        e_red = ((m_age / FL_T) % 2 == 0) ? 4'b1111 : 4'b0000;
      end
      default: ;
    endcase
    check_output("grn", 32'(grn), 32'(e_grn));
    check_output("yel", 32'(yel), 32'(e_yel));
    check_output("red", 32'(red), 32'(e_red));
    check_output("cur_phase", 32'(cur_phase), 32'(m_phase));
    check_output("in_flash", 32'(in_flash), 32'(e_fl));
    if (in_flash !== 1'b1)
      check_output("one_non_red", 32'($countones(~red) <= 1), 32'(1));
  endtask

  task automatic do_reset();
    repeat (3) apply_stimulus(4'b0000, 1'b0, 1'b0, 1'b1);
    check_output("rst_red", 32'(red), 32'(4'b1111));
    check_output("rst_grn", 32'(grn), 32'(4'b0000));
    check_output("rst_yel", 32'(yel), 32'(4'b0000));
    check_output("rst_cur_phase", 32'(cur_phase), 32'(3));
    check_output("rst_in_flash", 32'(in_flash), 32'(0));
  endtask

  initial begin
    logic [NP-1:0] r;
    logic          fm_r, fl_r, rs_r;
    checks     = 0;
    errors     = 0;
    req        = '0;
    fixed_mode = 1'b0;
    flash      = 1'b0;
    reset      = 1'b1;

    cur_test = "fixed";
    do_reset();
    for (int s = 0; s < 60; s++) begin
      apply_stimulus(4'b0000, 1'b1, 1'b0, 1'b0);
      if (s + 1 == 1)  check_output("p0_first", 32'(grn), 32'(4'b0001));
      if (s + 1 == 10) check_output("p0_last", 32'(grn), 32'(4'b0001));
      if (s + 1 == 11) check_output("p0_yel", 32'(yel), 32'(4'b0001));
      if (s + 1 == 13) check_output("clear", 32'(red), 32'(4'b1111));
      if (s + 1 == 14) check_output("p1_green", 32'(grn), 32'(4'b0010));
      if (s + 1 == 52) check_output("p3_clear", 32'(red), 32'(4'b1111));
      if (s + 1 == 53) check_output("p0_again", 32'(grn), 32'(4'b0001));
    end

    cur_test = "skip";
    do_reset();
    for (int s = 0; s < 30; s++) begin
      apply_stimulus((s == 5) ? 4'b0100 : 4'b0000, 1'b0, 1'b0, 1'b0);
      if (s + 1 == 6)  check_output("not_yet", 32'(grn), 32'(4'b0000));
      if (s + 1 == 7)  check_output("p2_green", 32'(grn), 32'(4'b0100));
      if (s + 1 == 30) check_output("p2_rest", 32'(grn), 32'(4'b0100));
    end

    cur_test = "max_green";
    do_reset();
    for (int s = 0; s < 25; s++) begin
      apply_stimulus(4'b0010 | ((s == 3) ? 4'b1000 : 4'b0000), 1'b0, 1'b0, 1'b0);
      if (s + 1 == 2)  check_output("p1_start", 32'(grn), 32'(4'b0010));
      if (s + 1 == 11) check_output("p1_g10", 32'(grn), 32'(4'b0010));
      if (s + 1 == 12) check_output("p1_yel", 32'(yel), 32'(4'b0010));
      if (s + 1 == 14) check_output("clear", 32'(red), 32'(4'b1111));
      if (s + 1 == 15) check_output("p3_green", 32'(grn), 32'(4'b1000));
    end

    cur_test = "gap_out";
    do_reset();
    for (int s = 0; s < 16; s++) begin
      r = ((s < 7) ? 4'b0010 : 4'b0000) | ((s == 3) ? 4'b1000 : 4'b0000);
      apply_stimulus(r, 1'b0, 1'b0, 1'b0);
      if (s + 1 == 7) check_output("p1_g6", 32'(grn), 32'(4'b0010));
      if (s + 1 == 8) check_output("p1_yel", 32'(yel), 32'(4'b0010));
    end

    cur_test = "flash";
    do_reset();
    for (int s = 0; s < 25; s++) begin
      r = (s == 0) ? 4'b0001 : ((s == 15) ? 4'b0010 : 4'b0000);
      apply_stimulus(r, 1'b0, (s >= 2 && s < 15), 1'b0);
      if (s + 1 == 2)  check_output("p0_green", 32'(grn), 32'(4'b0001));
      if (s + 1 == 3)  check_output("p0_yel", 32'(yel), 32'(4'b0001));
      if (s + 1 == 5)  check_output("clear_nf", 32'(in_flash), 32'(0));
      if (s + 1 == 6)  check_output("on_half", 32'(red), 32'(4'b1111));
      if (s + 1 == 6)  check_output("in_flash", 32'(in_flash), 32'(1));
      if (s + 1 == 9)  check_output("off_half", 32'(red), 32'(4'b0000));
      if (s + 1 == 12) check_output("on_again", 32'(red), 32'(4'b1111));
      if (s + 1 == 16) check_output("exit_red", 32'(red), 32'(4'b1111));
      if (s + 1 == 17) check_output("p1_green", 32'(grn), 32'(4'b0010));
    end

    cur_test = "wrap_reset";
    do_reset();
    for (int s = 0; s < 24; s++) begin
      r = (s == 0) ? 4'b0101 : ((s == 9) ? 4'b0001 : ((s == 10) ? 4'b0010 : 4'b0000));
      apply_stimulus(r, 1'b0, 1'b0, (s == 13));
      if (s + 1 == 2)  check_output("p0_first", 32'(grn), 32'(4'b0001));
      if (s + 1 == 9)  check_output("p2_next", 32'(grn), 32'(4'b0100));
      if (s + 1 == 13) check_output("p2_yel", 32'(yel), 32'(4'b0100));
      if (s + 1 == 14) check_output("rst_red", 32'(red), 32'(4'b1111));
      if (s + 1 == 14) check_output("rst_phase", 32'(cur_phase), 32'(3));
      if (s + 1 == 24) check_output("dem_gone", 32'(grn), 32'(4'b0000));
    end

    cur_test = "random";
    do_reset();
    fm_r = 1'b0;
    fl_r = 1'b0;
    for (int s = 0; s < 3000; s++) begin
      if (!fl_r && $urandom_range(0, 149) == 0) fl_r = 1'b1;
      else if (fl_r && $urandom_range(0, 19) == 0) fl_r = 1'b0;
      if ($urandom_range(0, 199) == 0) fm_r = ~fm_r;
      r    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      rs_r = ($urandom_range(0, 399) == 0);
      apply_stimulus(r, fm_r, fl_r, rs_r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
